// File: rtl/bs_pkg.sv
// Shared types, sizes and board-check helpers for the turn controller.
//   GRID      : number of board cells (4x4)
//   MAX_SHIPS : most ship cells a legal board may hold
//   state_e   : turn controller states
//   popcount  : number of set cells in a board/shot pattern
//   is_onehot : true when exactly one cell is set
package bs_pkg;

  localparam int unsigned GRID      = 16;
  localparam int unsigned MAX_SHIPS = 8;
  localparam int unsigned CNT_W     = $clog2(GRID + 1);
  localparam int unsigned SHOT_W    = 5;

  typedef enum logic [2:0] {
    LOAD,
    WAIT_PEER,
    A_AIM,
    A_WAIT,
    B_WAIT,
    WIN,
    LOSE
  } state_e;

  // Count set cells in a pattern.
  function automatic logic [CNT_W-1:0] popcount(input logic [GRID-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(GRID); i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  // Exactly one cell set.
  function automatic logic is_onehot(input logic [GRID-1:0] v);
    return popcount(v) == CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_rise.sv
// Optional multi-flop synchroniser followed by a one-register rise detector.
//   STAGES : synchroniser depth; 0 feeds din straight into the delay register
//   clk    : system clock
//   clr    : synchronous active-high clear of every register
//   din    : level input (asynchronous when STAGES > 0)
//   rise_c : combinational one-cycle pulse on a 0->1 of the (synchronised) level
module sync_rise #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic rise_c
);

  logic lvl;
  logic dly_q, dly_d;

  generate
    if (STAGES > 0) begin : g_sync
      logic [STAGES-1:0] sync_q, sync_d;

      // Shift din in at bit 0; the top bit is the synchronised level.
      always_comb begin
        sync_d = STAGES'({sync_q, din});
      end

      always_ff @(posedge clk) begin
        if (clr) sync_q <= '0;
        else     sync_q <= sync_d;
      end

      assign lvl = sync_q[STAGES-1];
    end else begin : g_direct
      assign lvl = din;
    end
  endgenerate

  always_comb begin
    dly_d = lvl;
  end

  always_ff @(posedge clk) begin
    if (clr) dly_q <= 1'b0;
    else     dly_q <= dly_d;
  end

  assign rise_c = lvl & ~dly_q;

endmodule

// File: rtl/master_turn_ctrl.sv
// Player-A turn controller for a two-board battleship game with a peer.
//   clk, clr        : clock, synchronous active-high reset
//   sw              : board pattern (LOAD) or shot target (A_AIM)
//   LDR1A / LDR2A   : debounced load / fire buttons
//   OKB, LivB       : peer strobe (async) and peer-alive flag
//   B_Attack        : peer shot, valid at the OKB rise
//   A, OKA          : our shot and handshake strobe to the peer
//   LivA            : any own ship cell left
//   turnA/win/lose  : state indicators
//   shots, board    : shots fired and own remaining cells for the display
module master_turn_ctrl
  import bs_pkg::*;
#(
  parameter int unsigned GRID      = bs_pkg::GRID,
  parameter int unsigned MAX_SHIPS = bs_pkg::MAX_SHIPS
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [GRID-1:0] sw,
  input  logic            LDR1A,
  input  logic            LDR2A,
  input  logic            OKB,
  input  logic            LivB,
  input  logic [GRID-1:0] B_Attack,
  output logic [GRID-1:0] A,
  output logic            OKA,
  output logic            LivA,
  output logic            turnA,
  output logic            win,
  output logic            lose,
  output logic [4:0]      shots,
  output logic [GRID-1:0] board
);

  localparam logic [SHOT_W-1:0] SHOT_MAX = SHOT_W'(16);

  state_e state_q, state_d;

  logic [GRID-1:0]   a_q, a_d;
  logic [GRID-1:0]   board_q, board_d;
  logic [GRID-1:0]   fired_q, fired_d;
  logic [SHOT_W-1:0] shots_q, shots_d;
  logic              oka_q, oka_d;
  logic              turna_q, turna_d;
  logic              win_q, win_d;
  logic              lose_q, lose_d;

  logic            okb_rise_c, ldr1_rise_c, ldr2_rise_c;
  logic [CNT_W-1:0] sw_cnt_c;
  logic            load_ok_c, fire_ok_c;
  logic [GRID-1:0] board_hit_c;

  // Peer strobe crosses clock domains; buttons are already synchronous.
  sync_rise #(.STAGES(2)) u_okb_rise (
    .clk(clk), .clr(clr), .din(OKB), .rise_c(okb_rise_c)
  );

  sync_rise #(.STAGES(0)) u_ldr1_rise (
    .clk(clk), .clr(clr), .din(LDR1A), .rise_c(ldr1_rise_c)
  );

  sync_rise #(.STAGES(0)) u_ldr2_rise (
    .clk(clk), .clr(clr), .din(LDR2A), .rise_c(ldr2_rise_c)
  );

  // Event qualifiers shared by next-state and output logic.
  always_comb begin
    sw_cnt_c    = popcount(sw);
    load_ok_c   = ldr1_rise_c && (sw_cnt_c != '0) && (sw_cnt_c <= CNT_W'(MAX_SHIPS));
    fire_ok_c   = ldr2_rise_c && is_onehot(sw) && ((sw & fired_q) == '0);
    board_hit_c = board_q & ~B_Attack;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (clr) state_q <= LOAD;
    else     state_q <= state_d;
  end

  // Next-state logic. A fire in A_AIM simply drops a coincident okb_rise.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:      if (load_ok_c)  state_d = WAIT_PEER;
      WAIT_PEER: if (okb_rise_c) state_d = A_AIM;
      A_AIM:     if (fire_ok_c)  state_d = A_WAIT;
      A_WAIT:    if (okb_rise_c) state_d = LivB ? B_WAIT : WIN;
      B_WAIT:    if (okb_rise_c) state_d = (board_hit_c == '0) ? LOSE : A_AIM;
      WIN:       state_d = WIN;
      LOSE:      state_d = LOSE;
      default:   state_d = LOAD;
    endcase
  end

  // Output / datapath logic. OKA is low unless a state holds or raises it.
  always_comb begin
    a_d     = a_q;
    board_d = board_q;
    fired_d = fired_q;
    shots_d = shots_q;
    oka_d   = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (load_ok_c) begin
          board_d = sw;
          oka_d   = 1'b1;
        end
      end
      WAIT_PEER: oka_d = ~okb_rise_c;
      A_AIM: begin
        if (fire_ok_c) begin
          a_d     = sw;
          fired_d = fired_q | sw;
          shots_d = (shots_q >= SHOT_MAX) ? SHOT_MAX : shots_q + SHOT_W'(1);
          oka_d   = 1'b1;
        end
      end
      A_WAIT: oka_d = ~okb_rise_c;
      B_WAIT: begin
        // Ack is a single-cycle pulse; A_AIM/LOSE drop it next cycle.
        if (okb_rise_c) begin
          board_d = board_hit_c;
          oka_d   = 1'b1;
        end
      end
      default: ;
    endcase
    turna_d = (state_d == A_AIM);
    win_d   = (state_d == WIN);
    lose_d  = (state_d == LOSE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      a_q     <= '0;
      board_q <= '0;
      fired_q <= '0;
      shots_q <= '0;
      oka_q   <= 1'b0;
      turna_q <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      board_q <= board_d;
      fired_q <= fired_d;
      shots_q <= shots_d;
      oka_q   <= oka_d;
      turna_q <= turna_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
    end
  end

  assign A     = a_q;
  assign OKA   = oka_q;
  assign LivA  = |board_q;
  assign turnA = turna_q;
  assign win   = win_q;
  assign lose  = lose_q;
  assign shots = shots_q;
  assign board = board_q;

endmodule

// File: tb/tb_master_turn_ctrl.sv
// Bench for master_turn_ctrl: directed game scenarios then random play,
// every cycle compared against a game-level reference model.
module tb_master_turn_ctrl;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [15:0] sw = '0;
  logic        LDR1A = 1'b0, LDR2A = 1'b0, OKB = 1'b0, LivB = 1'b1;
  logic [15:0] B_Attack = '0;
  logic [15:0] A, board;
  logic        OKA, LivA, turnA, win, lose;
  logic [4:0]  shots;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  master_turn_ctrl dut (
    .clk(clk), .clr(clr), .sw(sw), .LDR1A(LDR1A), .LDR2A(LDR2A),
    .OKB(OKB), .LivB(LivB), .B_Attack(B_Attack),
    .A(A), .OKA(OKA), .LivA(LivA), .turnA(turnA), .win(win), .lose(lose),
    .shots(shots), .board(board)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: game phases, own board, shot history, handshake level.
  localparam int PH_LOAD = 0, PH_WAITP = 1, PH_AIM = 2, PH_AWAIT = 3,
                 PH_BWAIT = 4, PH_WIN = 5, PH_LOSE = 6;
  int        m_phase = PH_LOAD;
  bit [15:0] m_board = '0, m_fired = '0, m_a = '0;
  int        m_shots = 0;
  bit        m_oka = 0;
  // OKB as sampled 1, 2, 3 edges ago; buttons as sampled last edge.
  bit        okb_h1 = 0, okb_h2 = 0, okb_h3 = 0, l1_prev = 0, l2_prev = 0;

  task automatic model_edge();
    bit rise, b1, b2;
    if (clr) begin
      m_phase = PH_LOAD; m_board = '0; m_fired = '0; m_a = '0;
      m_shots = 0; m_oka = 0;
      okb_h1 = 0; okb_h2 = 0; okb_h3 = 0; l1_prev = 0; l2_prev = 0;
      return;
    end
    rise = okb_h2 && !okb_h3;
    b1   = LDR1A && !l1_prev;
    b2   = LDR2A && !l2_prev;
    case (m_phase)
      PH_LOAD:
        if (b1 && $countones(sw) >= 1 && $countones(sw) <= 8) begin
          m_board = sw; m_oka = 1; m_phase = PH_WAITP;
        end
      PH_WAITP:
        if (rise) begin m_oka = 0; m_phase = PH_AIM; end
      PH_AIM: begin
        m_oka = 0;
        if (b2 && $onehot(sw) && (sw & m_fired) == 0) begin
          m_a = sw; m_fired = m_fired | sw;
          m_shots = (m_shots + 1 > 16) ? 16 : m_shots + 1;
          m_oka = 1; m_phase = PH_AWAIT;
        end
      end
      PH_AWAIT:
        if (rise) begin m_oka = 0; m_phase = LivB ? PH_BWAIT : PH_WIN; end
      PH_BWAIT:
        if (rise) begin
          m_board = m_board & ~B_Attack; m_oka = 1;
          m_phase = (m_board == 0) ? PH_LOSE : PH_AIM;
        end
      default: m_oka = 0;
    endcase
    okb_h3 = okb_h2; okb_h2 = okb_h1; okb_h1 = OKB;
    l1_prev = LDR1A; l2_prev = LDR2A;
  endtask

  // One clock: update the model at the edge, compare on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("A",     32'(A),     32'(m_a));
    check_eq("OKA",   32'(OKA),   32'(m_oka));
    check_eq("LivA",  32'(LivA),  32'(m_board != 0));
    check_eq("turnA", 32'(turnA), 32'(m_phase == PH_AIM));
    check_eq("win",   32'(win),   32'(m_phase == PH_WIN));
    check_eq("lose",  32'(lose),  32'(m_phase == PH_LOSE));
    check_eq("shots", 32'(shots), 32'(m_shots));
    check_eq("board", 32'(board), 32'(m_board));
  endtask

  task automatic do_clr();
    clr = 1'b1; OKB = 1'b0; LDR1A = 1'b0; LDR2A = 1'b0;
    cyc(); cyc();
    clr = 1'b0;
    cyc();
  endtask

  task automatic press1(input logic [15:0] v);
    sw = v; LDR1A = 1'b1; cyc(); LDR1A = 1'b0; cyc();
  endtask

  task automatic press2(input logic [15:0] v);
    sw = v; LDR2A = 1'b1; cyc(); LDR2A = 1'b0; cyc();
  endtask

  task automatic okb_pulse(input logic liv, input logic [15:0] atk);
    LivB = liv; B_Attack = atk;
    OKB = 1'b1; repeat (4) cyc();
    OKB = 1'b0; repeat (3) cyc();
  endtask

  initial begin
    // Reset state and illegal loads (too many cells, empty board).
    do_clr();
    check_eq("reset_board", 32'(board), 32'h0);
    press1(16'h01FF);
    press1(16'h0000);
    check_eq("illegal_load_oka", 32'(OKA), 32'h0);
    // Legal load, peer ready, fire, peer survives.
    press1(16'h000F);
    check_eq("load_board", 32'(board), 32'h000F);
    okb_pulse(1'b1, 16'h0000);
    press2(16'h0010);
    check_eq("shot_a", 32'(A), 32'h0010);
    okb_pulse(1'b1, 16'h0000);
    // Peer misses; repeat and multi-hot shots are ignored.
    okb_pulse(1'b1, 16'h0100);
    press2(16'h0010);
    press2(16'h0011);
    check_eq("repeat_shots", 32'(shots), 32'd1);
    // Simultaneous okb rise and fire: shot wins, rise discarded.
    sw = 16'h0020; OKB = 1'b1; cyc(); cyc();
    LDR2A = 1'b1; cyc(); LDR2A = 1'b0; repeat (3) cyc();
    OKB = 1'b0; repeat (3) cyc();
    okb_pulse(1'b1, 16'h0000);
    // Multi-hot attack sinks the whole board: lose, then inert.
    okb_pulse(1'b1, 16'h000F);
    check_eq("lose_flag", 32'(lose), 32'h1);
    okb_pulse(1'b1, 16'h0000);
    press1(16'h0003);
    press2(16'h0040);

    // Reset in the middle of a handshake.
    do_clr();
    press1(16'h0001);
    okb_pulse(1'b1, 16'h0000);
    press2(16'h8000);
    OKB = 1'b1; cyc(); cyc();
    clr = 1'b1; cyc();
    check_eq("clr_mid_oka", 32'(OKA), 32'h0);
    clr = 1'b0; OKB = 1'b0; repeat (3) cyc();

    // Win: peer reports dead.
    press1(16'h0001);
    okb_pulse(1'b1, 16'h0000);
    press2(16'h0002);
    okb_pulse(1'b0, 16'h0000);
    check_eq("win_flag", 32'(win), 32'h1);
    press2(16'h0004);

    // Random play with occasional resets.
    do_clr();
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 299));
      clr = (r == 0);
      if ($urandom_range(0, 3) == 0) LDR1A = ~LDR1A;
      if ($urandom_range(0, 3) == 0) LDR2A = ~LDR2A;
      if ($urandom_range(0, 5) == 0) OKB = ~OKB;
      case ($urandom_range(0, 3))
        0, 1: sw = 16'h1 << $urandom_range(0, 15);
        2:    sw = 16'($urandom);
        default: sw = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      endcase
      B_Attack = ($urandom_range(0, 9) < 8) ? (16'h1 << $urandom_range(0, 15)) : 16'($urandom);
      LivB = ($urandom_range(0, 9) < 8);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/master_turn_ctrl.md
MASTER_TURN_CTRL -- requirements
Module: master_turn_ctrl

Interface
REQ-001 SHALL have parameter GRID, default 16, meaning number of board cells (4x4).
REQ-002 SHALL have parameter MAX_SHIPS, default 8, meaning maximum number of set bits in a legal board.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock.
REQ-004 SHALL have port clr, input, 1, meaning reset: synchronous, active-high.
REQ-005 SHALL have port sw, input, GRID, meaning player A switches (board pattern or shot target).
REQ-006 SHALL have port LDR1A, input, 1, meaning debounced "load board" button.
REQ-007 SHALL have port LDR2A, input, 1, meaning debounced "fire" button.
REQ-008 SHALL have port OKB, input, 1, meaning peer strobe, asynchronous to clk.
REQ-009 SHALL have port LivB, input, 1, meaning peer alive, valid at the OKB rise.
REQ-010 SHALL have port B_Attack, input, GRID, meaning peer shot, valid at the OKB rise.
REQ-011 SHALL have port A, output, GRID, meaning current shot sent to the peer.
REQ-012 SHALL have port OKA, output, 1, meaning handshake strobe to the peer.
REQ-013 SHALL have port LivA, output, 1, meaning OR-reduction of own remaining board.
REQ-014 SHALL have port turnA, output, 1, meaning high while in A_AIM.
REQ-015 SHALL have port win, output, 1, meaning state is WIN.
REQ-016 SHALL have port lose, output, 1, meaning state is LOSE.
REQ-017 SHALL have port shots, output, 5, meaning number of shots fired by A.
REQ-018 SHALL have port board, output, GRID, meaning own remaining ship cells, for the display.

Function
REQ-019 SHALL synchronise OKB through 2 flops and detect its rise from the 2nd stage against a delay register (okb_rise).
- Action occurs at the 3rd clk edge sampling OKB=1.
- LivB and B_Attack are sampled at that same edge, unsynchronised; the peer holds them stable.
REQ-020 SHALL detect rising edges of LDR1A and LDR2A with one delay register each; a held button acts once.
REQ-021 SHALL implement the FSM with states LOAD, WAIT_PEER, A_AIM, A_WAIT, B_WAIT, WIN, LOSE.
REQ-022 LOAD: on LDR1A rise with popcount(sw) in 1..MAX_SHIPS -> board<=sw, OKA<=1, go to WAIT_PEER; illegal sw is ignored and the state is held.
REQ-023 WAIT_PEER: OKA held 1; on okb_rise -> OKA<=0, go to A_AIM (A always fires first).
REQ-024 A_AIM: on LDR2A rise with sw one-hot and (sw & fired)==0 -> A<=sw, fired|=sw, shots+=1, OKA<=1, go to A_WAIT; otherwise ignore.
REQ-025 A_WAIT: on okb_rise -> OKA<=0; go to WIN if LivB==0, else to B_WAIT.
REQ-026 B_WAIT: on okb_rise -> board<=board & ~B_Attack; OKA pulses 1 for exactly one cycle (the ack).
- Next state is LOSE if the new board==0, else A_AIM.
- A non-one-hot B_Attack is still applied as a mask (peer responsibility).
REQ-027 WIN and LOSE SHALL be terminal until clr; okb_rise and both buttons are ignored there.
REQ-028 LivA SHALL equal |board combinationally; it therefore falls in the same cycle the board becomes 0.
REQ-029 shots SHALL saturate at 16; the fired mask prevents any 17th legal shot.
REQ-030 LDR1A and LDR2A rises SHALL be ignored in every state other than the one that consumes them.
REQ-031 Simultaneous okb_rise and LDR2A rise in A_AIM SHALL fire the shot and discard the okb_rise.

Reset
REQ-032 clr SHALL set: state=LOAD; A, board, fired, shots = 0; OKA, win, lose, turnA = 0; LivA = 0.
REQ-033 clr SHALL also zero the sync, delay and edge registers.
REQ-034 clr SHALL override every event in the same cycle, including mid-handshake.
REQ-035 clr SHALL be sampled only on clk rising edges.

Structure
REQ-036 Package bs_pkg SHALL hold the state enum type, GRID and MAX_SHIPS.
REQ-037 Sub-module sync_rise (2-flop synchroniser plus rise detector, parameter STAGES=2) SHALL be instantiated for OKB.
REQ-038 Button edge detection SHALL use a single-register variant of sync_rise (STAGES=0).
REQ-039 The popcount and one-hot checks SHALL be combinational functions in bs_pkg.

Verification
REQ-040 Board load: clr, sw=16'h000F, LDR1A pulse -> board=000F, LivA=1, OKA=1, state WAIT_PEER.
REQ-041 Illegal load: sw=16'h01FF (9 bits) or 0000, LDR1A -> state stays LOAD, OKA=0.
REQ-042 Shot, peer survives: from A_AIM, sw=16'h0010, LDR2A -> A=0010, OKA=1, shots=1.
- Then OKB rise with LivB=1 -> OKA=0 at the 3rd edge after the rise, state B_WAIT.
REQ-043 Repeat/multi-hot shot: sw=16'h0010 again, or sw=16'h0011 -> ignored, shots unchanged.
REQ-044 Peer hit and loss: board=0001, in B_WAIT, B_Attack=0001, OKB rise -> board=0, LivA=0, one-cycle OKA pulse, lose=1.
- Later okb_rise and button rises produce no change.
REQ-045 Win and reset mid-handshake: A_WAIT, OKB rise with LivB=0 -> win=1.
- Separately, clr asserted in A_WAIT -> all outputs at reset values on the next edge.
